// File: rtl/elevator_pkg.sv
// Shared types and defaults for the elevator SCAN scheduler.
package elevator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MOVE = 2'd1,
        ST_DOOR = 2'd2
    } state_t;

    localparam logic [1:0] DIR_IDLE = 2'd0;
    localparam logic [1:0] DIR_UP   = 2'd1;
    localparam logic [1:0] DIR_DOWN = 2'd2;

    localparam int DEF_NUM_FLOORS = 8;
    localparam int DEF_FLOOR_W    = 3;
    localparam int DEF_MAX_WEIGHT = 900;

endpackage

// File: rtl/elevator_scan_pick.sv
// SCAN direction pick: keep going the current way while calls remain ahead,
// otherwise reverse; DIR_IDLE means no call is pending anywhere else.
module elevator_scan_pick
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = DEF_NUM_FLOORS,
    parameter int FLOOR_W    = DEF_FLOOR_W
) (
    input  logic [FLOOR_W-1:0]    i_floor,
    input  logic [1:0]            i_dir,
    input  logic [NUM_FLOORS-1:0] i_pending,
    output logic [1:0]            o_next_dir
);

    logic w_above;
    logic w_below;

    always_comb begin
        w_above = 1'b0;
        w_below = 1'b0;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            if (i_pending[f]) begin
                if (f > int'(i_floor)) w_above = 1'b1;
                if (f < int'(i_floor)) w_below = 1'b1;
            end
        end
    end

    always_comb begin
        o_next_dir = DIR_IDLE;
        if (i_dir == DIR_DOWN) begin
            if (w_below)      o_next_dir = DIR_DOWN;
            else if (w_above) o_next_dir = DIR_UP;
        end else begin
            if (w_above)      o_next_dir = DIR_UP;
            else if (w_below) o_next_dir = DIR_DOWN;
        end
    end

endmodule

// File: rtl/elevator_scan_scheduler.sv
// Elevator car sequencer: call latch, SCAN stop selection, travel/dwell timing
// and overweight hold. Define PARK_HOME_EN to return an idle car to floor 0.
module elevator_scan_scheduler
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS    = DEF_NUM_FLOORS,
    parameter int FLOOR_W       = DEF_FLOOR_W,
    parameter int TRAVEL_CYCLES = 16,
    parameter int DOOR_CYCLES   = 32,
    parameter int MAX_WEIGHT    = DEF_MAX_WEIGHT,
    parameter int PARK_CYCLES   = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [FLOOR_W-1:0]    req_floor,
    input  logic [10:0]           weight,
    output logic [FLOOR_W-1:0]    out_floor,
    output logic [1:0]            direction,
    output logic                  moving,
    output logic                  door_open,
    output logic                  arrive,
    output logic                  complete,
    output logic                  over_weight,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam int TMAX    = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TIMER_W = $clog2(TMAX + 1);

    if (TRAVEL_CYCLES < 2 || DOOR_CYCLES < 2 || PARK_CYCLES < 1) begin : g_param_chk
        $error("elevator_scan_scheduler: timing parameters out of range");
    end

    state_t                  r_state;
    logic [FLOOR_W-1:0]      r_floor;
    logic [1:0]              r_dir;
    logic                    r_moving;
    logic                    r_door;
    logic                    r_arrive;
    logic [NUM_FLOORS-1:0]   r_pending;
    logic [TIMER_W-1:0]      r_timer;

    logic [1:0]              w_pick;
    logic [FLOOR_W-1:0]      w_next_floor;
    logic                    w_req_ok;
    logic                    w_floor_call;
    logic                    w_over;
    logic                    w_expire;
    logic                    w_stop;
    logic [NUM_FLOORS-1:0]   w_set_mask;
    logic [NUM_FLOORS-1:0]   w_clr_mask;
    logic [NUM_FLOORS-1:0]   w_pend_nxt;

    elevator_scan_pick #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_pick (
        .i_floor    (r_floor),
        .i_dir      (r_dir),
        .i_pending  (r_pending),
        .o_next_dir (w_pick)
    );

    assign w_next_floor = (r_dir == DIR_DOWN) ? (r_floor - FLOOR_W'(1)) : (r_floor + FLOOR_W'(1));
    assign w_req_ok     = req_valid && (int'(req_floor) < NUM_FLOORS);
    // A call for the floor the car is standing at never enters the bitmap.
    assign w_floor_call = w_req_ok && (req_floor == r_floor) &&
                          ((r_state == ST_IDLE) || (r_state == ST_DOOR));
    assign w_over       = r_door && (int'(weight) > MAX_WEIGHT);
    assign w_expire     = (r_timer == TIMER_W'(1));
    assign w_stop       = (r_state == ST_MOVE) && w_expire && r_pending[w_next_floor];

    assign w_set_mask = (w_req_ok && !w_floor_call) ?
                        ({{(NUM_FLOORS-1){1'b0}}, 1'b1} << req_floor) : '0;
    assign w_clr_mask = w_stop ?
                        ({{(NUM_FLOORS-1){1'b0}}, 1'b1} << w_next_floor) : '0;
    assign w_pend_nxt = (r_pending | w_set_mask) & ~w_clr_mask;

`ifdef PARK_HOME_EN
    localparam int PARK_W = $clog2(PARK_CYCLES + 1);

    logic [PARK_W-1:0] r_park_cnt;
    logic              r_park;
    logic              w_park_cond;
    logic              w_park_go;

    assign w_park_cond = (r_state == ST_IDLE) && (r_pending == '0) && (r_floor != '0);
    assign w_park_go   = w_park_cond && (r_park_cnt >= PARK_W'(PARK_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_park_cnt <= '0;
        end else if (!w_park_cond) begin
            r_park_cnt <= '0;
        end else if (!w_park_go) begin
            r_park_cnt <= r_park_cnt + PARK_W'(1);
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_floor   <= '0;
            r_dir     <= DIR_IDLE;
            r_moving  <= 1'b0;
            r_door    <= 1'b0;
            r_arrive  <= 1'b0;
            r_pending <= '0;
            r_timer   <= '0;
`ifdef PARK_HOME_EN
            r_park    <= 1'b0;
`endif
        end else begin
            r_arrive  <= 1'b0;
            r_pending <= w_pend_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (w_floor_call) begin
                        r_state  <= ST_DOOR;
                        r_door   <= 1'b1;
                        r_arrive <= 1'b1;
                        r_timer  <= TIMER_W'(DOOR_CYCLES);
                    end else if (w_pick != DIR_IDLE) begin
                        r_state  <= ST_MOVE;
                        r_dir    <= w_pick;
                        r_moving <= 1'b1;
                        r_timer  <= TIMER_W'(TRAVEL_CYCLES);
                    end
`ifdef PARK_HOME_EN
                    else if (w_park_go) begin
                        r_state  <= ST_MOVE;
                        r_dir    <= DIR_DOWN;
                        r_moving <= 1'b1;
                        r_park   <= 1'b1;
                        r_timer  <= TIMER_W'(TRAVEL_CYCLES);
                    end
`endif
                end
                ST_MOVE: begin
                    if (w_expire) begin
                        r_floor <= w_next_floor;
                        if (r_pending[w_next_floor]) begin
                            r_state  <= ST_DOOR;
                            r_door   <= 1'b1;
                            r_arrive <= 1'b1;
                            r_moving <= 1'b0;
                            r_timer  <= TIMER_W'(DOOR_CYCLES);
`ifdef PARK_HOME_EN
                            r_park   <= 1'b0;
`endif
                        end
`ifdef PARK_HOME_EN
                        // Parking yields to new calls at the floor boundary; IDLE re-picks.
                        else if (r_park && ((r_pending != '0) || (w_next_floor == '0))) begin
                            r_state  <= ST_IDLE;
                            r_dir    <= DIR_IDLE;
                            r_moving <= 1'b0;
                            r_park   <= 1'b0;
                        end
`endif
                        else begin
                            r_timer <= TIMER_W'(TRAVEL_CYCLES);
                        end
                    end else begin
                        r_timer <= r_timer - TIMER_W'(1);
                    end
                end
                ST_DOOR: begin
                    if (w_floor_call || w_over) begin
                        r_timer <= TIMER_W'(DOOR_CYCLES);
                    end else if (w_expire) begin
                        r_door <= 1'b0;
                        if (w_pick == DIR_IDLE) begin
                            r_state <= ST_IDLE;
                            r_dir   <= DIR_IDLE;
                        end else begin
                            r_state  <= ST_MOVE;
                            r_dir    <= w_pick;
                            r_moving <= 1'b1;
                            r_timer  <= TIMER_W'(TRAVEL_CYCLES);
                        end
                    end else begin
                        r_timer <= r_timer - TIMER_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out_floor   = r_floor;
    assign direction   = r_dir;
    assign moving      = r_moving;
    assign door_open   = r_door;
    assign arrive      = r_arrive;
    assign over_weight = w_over;
    assign pending     = r_pending;
    assign complete    = (r_state == ST_IDLE) && (r_pending == '0);

endmodule

// File: tb/tb_elevator_scan_scheduler.sv
// Directed bench for elevator_scan_scheduler (TRAVEL_CYCLES = 4, DOOR_CYCLES = 8).
module tb_elevator_scan_scheduler;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic [2:0] req_floor;
    logic [10:0] weight;
    logic [2:0] out_floor;
    logic [1:0] direction;
    logic       moving;
    logic       door_open;
    logic       arrive;
    logic       complete;
    logic       over_weight;
    logic [7:0] pending;

    int n_checks = 0;
    int n_errors = 0;
    int n_arrive = 0;
    logic mon_en = 1'b0;

    elevator_scan_scheduler #(
        .NUM_FLOORS    (8),
        .FLOOR_W       (3),
        .TRAVEL_CYCLES (4),
        .DOOR_CYCLES   (8),
        .MAX_WEIGHT    (900),
        .PARK_CYCLES   (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_floor   (req_floor),
        .weight      (weight),
        .out_floor   (out_floor),
        .direction   (direction),
        .moving      (moving),
        .door_open   (door_open),
        .arrive      (arrive),
        .complete    (complete),
        .over_weight (over_weight),
        .pending     (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!mon_en) n_arrive <= 0;
        else if (arrive) n_arrive <= n_arrive + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic call(input logic [2:0] f);
        req_valid = 1'b1;
        req_floor = f;
        tick(1);
        req_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_floor = '0; weight = 11'd500;
        tick(1);
        chk("rst_floor", 32'(out_floor), 0);
        chk("rst_dir", 32'(direction), 0);
        chk("rst_moving", 32'(moving), 0);
        chk("rst_door", 32'(door_open), 0);
        chk("rst_arrive", 32'(arrive), 0);
        chk("rst_over", 32'(over_weight), 0);
        chk("rst_complete", 32'(complete), 1);
        chk("rst_pending", 32'(pending), 0);
        rst = 1'b0;

        // Floor 0 -> 5
        call(3'd5);
        chk("s1_pend", 32'(pending), 32'h20);
        chk("s1_dir0", 32'(direction), 0);
        tick(1);
        chk("s1_dir", 32'(direction), 1);
        chk("s1_moving", 32'(moving), 1);
        tick(19);
        chk("s1_fl4", 32'(out_floor), 4);
        chk("s1_nodoor", 32'(door_open), 0);
        tick(1);
        chk("s1_fl5", 32'(out_floor), 5);
        chk("s1_door", 32'(door_open), 1);
        chk("s1_arrive", 32'(arrive), 1);
        chk("s1_stop", 32'(moving), 0);
        chk("s1_pclr", 32'(pending), 0);
        tick(1);
        chk("s1_arr_pulse", 32'(arrive), 0);
        tick(6);
        chk("s1_dwell", 32'(door_open), 1);
        tick(1);
        chk("s1_close", 32'(door_open), 0);
        chk("s1_idle_dir", 32'(direction), 0);
        chk("s1_complete", 32'(complete), 1);

        // Floor 5 -> 2, then overweight hold at 2
        call(3'd2);
        tick(1);
        chk("ow_dir", 32'(direction), 2);
        tick(12);
        chk("ow_fl2", 32'(out_floor), 2);
        chk("ow_door", 32'(door_open), 1);
        weight = 11'd950;
        req_valid = 1'b1; req_floor = 3'd6;
        #1;
        chk("ow_flag", 32'(over_weight), 1);
        tick(1);
        req_valid = 1'b0;
        chk("ow_pend", 32'(pending), 32'h40);
        tick(19);
        chk("ow_hold_flag", 32'(over_weight), 1);
        chk("ow_hold_door", 32'(door_open), 1);
        weight = 11'd800;
        #1;
        chk("ow_clear", 32'(over_weight), 0);
        tick(7);
        chk("ow_still_open", 32'(door_open), 1);
        tick(1);
        chk("ow_depart_door", 32'(door_open), 0);
        chk("ow_depart_mv", 32'(moving), 1);
        chk("ow_depart_dir", 32'(direction), 1);

        // Travelling 2 -> 6: call 4 in flight, call 1 at floor 4
        tick(1);
        call(3'd4);
        chk("op_pend", 32'(pending), 32'h50);
        tick(5);
        chk("op_fl3", 32'(out_floor), 3);
        chk("op_mv3", 32'(moving), 1);
        tick(1);
        chk("op_fl4", 32'(out_floor), 4);
        chk("op_door4", 32'(door_open), 1);
        chk("op_arr4", 32'(arrive), 1);
        chk("op_pend4", 32'(pending), 32'h40);
        call(3'd1);
        chk("sc_pend42", 32'(pending), 32'h42);
        tick(7);
        chk("sc_leave4", 32'(moving), 1);
        chk("sc_dir_up", 32'(direction), 1);
        tick(8);
        chk("sc_fl6", 32'(out_floor), 6);
        chk("sc_door6", 32'(door_open), 1);
        chk("sc_pend02", 32'(pending), 32'h02);
        tick(3);
        call(3'd6);
        chk("ab_pend", 32'(pending), 32'h02);
        tick(7);
        chk("ab_dwell", 32'(door_open), 1);
        tick(1);
        chk("ab_close", 32'(door_open), 0);
        chk("sc_rev_dir", 32'(direction), 2);
        chk("sc_rev_mv", 32'(moving), 1);
        tick(20);
        chk("sc_fl1", 32'(out_floor), 1);
        chk("sc_door1", 32'(door_open), 1);
        chk("sc_pend00", 32'(pending), 0);
        tick(8);
        chk("sc_idle_dir", 32'(direction), 0);
        chk("sc_complete", 32'(complete), 1);

        // Asynchronous reset in the middle of travel
        call(3'd4);
        tick(1);
        tick(5);
        chk("ar_fl2", 32'(out_floor), 2);
        rst = 1'b1;
        #1;
        chk("ar_floor", 32'(out_floor), 0);
        chk("ar_dir", 32'(direction), 0);
        chk("ar_moving", 32'(moving), 0);
        chk("ar_pending", 32'(pending), 0);
        chk("ar_complete", 32'(complete), 1);
        tick(1);
        rst = 1'b0;

        // Idle at floor 3, then watch for parking
        call(3'd3);
        tick(1);
        tick(12);
        chk("pk_fl3", 32'(out_floor), 3);
        tick(8);
        chk("pk_idle", 32'(complete), 1);
        mon_en = 1'b1;
        tick(40);
        chk("pk_no_arrive", 32'(n_arrive), 0);
        chk("pk_dir", 32'(direction), 0);
`ifdef PARK_HOME_EN
        chk("pk_floor", 32'(out_floor), 0);
`else
        chk("pk_floor", 32'(out_floor), 3);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
